// File: rtl/lvt_mem_2w4r.sv
// Two-write four-read memory built from replicated 1W1R banks steered by a live value table.
// Latency: one cycle from read address to registered d1..d4; after reset an INIT pass clears all 2<<BLOCKSIZE words.
// Backpressure: none; ready stays low through INIT, and writes presented while ready is low are dropped.
//
// Ports: clk, rst (sync, active-high); w1/w2 _addr/_din with en_w1/en_w2 write ports;
//        r1..r4_addr read addresses; d1..d4 registered read data; ready = INIT done.
// Optional feature: define LVT_BYPASS_EN to forward same-cycle write data to matching reads
//        (port 1 wins on a dual match). The default build is strictly read-before-write.
module lvt_mem_2w4r #(
    parameter int BLOCKSIZE = 10,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCKSIZE:0]   w1_addr,
    input  logic [BLOCKSIZE:0]   w2_addr,
    input  logic [DATA_W-1:0]    w1_din,
    input  logic [DATA_W-1:0]    w2_din,
    input  logic                 en_w1,
    input  logic                 en_w2,
    input  logic [BLOCKSIZE:0]   r1_addr,
    input  logic [BLOCKSIZE:0]   r2_addr,
    input  logic [BLOCKSIZE:0]   r3_addr,
    input  logic [BLOCKSIZE:0]   r4_addr,
    output logic [DATA_W-1:0]    d1,
    output logic [DATA_W-1:0]    d2,
    output logic [DATA_W-1:0]    d3,
    output logic [DATA_W-1:0]    d4,
    output logic                 ready
);

    localparam int DEPTH = 2 << BLOCKSIZE;
    localparam logic [BLOCKSIZE:0] LAST_ADDR = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [BLOCKSIZE:0]  cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   d_q [4];
    logic [DATA_W-1:0]   d_d [4];

    logic [BLOCKSIZE:0]  raddr  [4];
    logic [DATA_W-1:0]   rd_dat [4];

    // Effective bank write controls: INIT borrows both ports to clear address cnt_q.
    logic                in_init;
    logic                we1, we2;
    logic [BLOCKSIZE:0]  wa1, wa2;
    logic [DATA_W-1:0]   wd1, wd2;

    // 0 = port-1 banks hold the live value, 1 = port-2 banks.
    logic                lvt_mem [DEPTH];

    assign raddr[0] = r1_addr;
    assign raddr[1] = r2_addr;
    assign raddr[2] = r3_addr;
    assign raddr[3] = r4_addr;

    always_comb begin
        in_init = (state_q == S_INIT);
        we1     = !rst && (in_init || en_w1);
        we2     = !rst && (in_init || en_w2);
        wa1     = in_init ? cnt_q : w1_addr;
        wa2     = in_init ? cnt_q : w2_addr;
        wd1     = in_init ? '0 : w1_din;
        wd2     = in_init ? '0 : w2_din;
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_init) begin
                lvt_mem[cnt_q] <= 1'b0;
            end else begin
                if (en_w2) lvt_mem[w2_addr] <= 1'b1;
                if (en_w1) lvt_mem[w1_addr] <= 1'b0;
            end
        end
    end

    // Bank pair per read port: b1 = B[1][r], b2 = B[2][r].
    for (genvar r = 0; r < 4; r++) begin : g_rd
        logic [DATA_W-1:0] b1 [DEPTH];
        logic [DATA_W-1:0] b2 [DEPTH];

        always_ff @(posedge clk) begin
            if (we1) b1[wa1] <= wd1;
            if (we2) b2[wa2] <= wd2;
        end

        assign rd_dat[r] = lvt_mem[raddr[r]] ? b2[raddr[r]] : b1[raddr[r]];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_init) begin
            // Hold at the last address instead of wrapping; leaving INIT ends the pass.
            if (cnt_q == LAST_ADDR) state_d = S_RUN;
            else                    cnt_d   = cnt_q + 1'b1;
        end
        ready_d = (state_d == S_RUN);

        for (int r = 0; r < 4; r++) begin
            d_d[r] = '0;
            if (!in_init) begin
                d_d[r] = rd_dat[r];
`ifdef LVT_BYPASS_EN
                if (en_w1 && (w1_addr == raddr[r]))      d_d[r] = w1_din;
                else if (en_w2 && (w2_addr == raddr[r])) d_d[r] = w2_din;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            for (int r = 0; r < 4; r++) d_q[r] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            for (int r = 0; r < 4; r++) d_q[r] <= d_d[r];
        end
    end

    assign d1    = d_q[0];
    assign d2    = d_q[1];
    assign d3    = d_q[2];
    assign d4    = d_q[3];
    assign ready = ready_q;

endmodule

// File: tb/tb_lvt_mem_2w4r.sv
module tb_lvt_mem_2w4r;

    localparam int BS    = 10;
    localparam int DW    = 32;
    localparam int AW    = BS + 1;
    localparam int DEPTH = 2 << BS;
`ifdef LVT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] w1_addr, w2_addr;
    logic [DW-1:0] w1_din, w2_din;
    logic          en_w1, en_w2;
    logic [AW-1:0] ra [4];
    logic [DW-1:0] d1, d2, d3, d4;
    logic          ready;

    always #5 clk = ~clk;

    lvt_mem_2w4r #(.BLOCKSIZE(BS), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .w1_addr (w1_addr),
        .w2_addr (w2_addr),
        .w1_din  (w1_din),
        .w2_din  (w2_din),
        .en_w1   (en_w1),
        .en_w2   (en_w2),
        .r1_addr (ra[0]),
        .r2_addr (ra[1]),
        .r3_addr (ra[2]),
        .r4_addr (ra[3]),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .d4      (d4),
        .ready   (ready)
    );

    typedef logic [3:0][DW-1:0] quad_t;
    typedef logic [3:0][AW-1:0] raq_t;

    typedef struct {
        string nm;
        quad_t exp;
    } sb_t;

    typedef struct {
        logic          e1;
        logic [AW-1:0] a1;
        logic [DW-1:0] v1;
        logic          e2;
        logic [AW-1:0] a2;
        logic [DW-1:0] v2;
        raq_t          rd;
        quad_t         exp;
    } vec_t;

    sb_t           sbq [$];
    vec_t          vt [15];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            model_run;
    int            n_cmp;
    int            n_bad;

    // Reference read of the current inputs, as observed one edge later.
    function automatic quad_t model_exp();
        quad_t q;
        for (int r = 0; r < 4; r++) begin
            if (!model_run || rst)                       q[r] = '0;
            else if (BYP && en_w1 && w1_addr == ra[r])   q[r] = w1_din;
            else if (BYP && en_w2 && w2_addr == ra[r])   q[r] = w2_din;
            else                                         q[r] = ref_mem[ra[r]];
        end
        return q;
    endfunction

    function automatic vec_t mk(input logic e1, input int a1, input logic [DW-1:0] v1,
                                input logic e2, input int a2, input logic [DW-1:0] v2,
                                input int r0, input int r1, input int r2, input int r3,
                                input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                                input logic [DW-1:0] x2, input logic [DW-1:0] x3);
        vec_t v;
        v.e1 = e1; v.a1 = AW'(a1); v.v1 = v1;
        v.e2 = e2; v.a2 = AW'(a2); v.v2 = v2;
        v.rd[0] = AW'(r0); v.rd[1] = AW'(r1); v.rd[2] = AW'(r2); v.rd[3] = AW'(r3);
        v.exp[0] = x0; v.exp[1] = x1; v.exp[2] = x2; v.exp[3] = x3;
        return v;
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    // Push the expectation, update the model for accepted writes, clock, then pop and compare.
    task automatic cycle(input string nm, input quad_t exp);
        sb_t e;
        e.nm  = nm;
        e.exp = exp;
        sbq.push_back(e);
        if (model_run && !rst) begin
            if (en_w2) ref_mem[w2_addr] = w2_din;
            if (en_w1) ref_mem[w1_addr] = w1_din;
        end
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        n_cmp++;
        if ({d4, d3, d2, d1} !== e.exp) begin
            n_bad++;
            $display("FAIL %s: d1..d4 got %h %h %h %h required %h %h %h %h", e.nm,
                     d1, d2, d3, d4, e.exp[0], e.exp[1], e.exp[2], e.exp[3]);
        end
    endtask

    task automatic idle_inputs();
        en_w1 = 1'b0; en_w2 = 1'b0;
        w1_addr = '0; w2_addr = '0; w1_din = '0; w2_din = '0;
        for (int r = 0; r < 4; r++) ra[r] = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic rand_inputs(input bit wr);
        en_w1   = wr && ($urandom_range(0, 1) == 1);
        en_w2   = wr && ($urandom_range(0, 1) == 1);
        w1_addr = rand_addr();
        w2_addr = ($urandom_range(0, 7) == 0) ? w1_addr : rand_addr();
        w1_din  = DW'($urandom_range(0, 255));
        w2_din  = DW'($urandom_range(0, 255));
        for (int r = 0; r < 4; r++) begin
            ra[r] = ($urandom_range(0, 5) == 0) ? w1_addr : rand_addr();
        end
    endtask

    // One reset pulse followed by either the full INIT pass (checked) or a partial one.
    task automatic do_reset(input bit full);
        int lowcnt;
        rst = 1'b1;
        model_run = 1'b0;
        rand_inputs(1'b1);
        cycle("reset_cycle", model_exp());
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        lowcnt = (ready == 1'b0) ? 1 : 0;
        for (int i = 1; i < (full ? DEPTH : 700); i++) begin
            rand_inputs(1'b1);
            cycle("init_reads_zero", model_exp());
            if (ready == 1'b0) lowcnt++;
        end
        if (full) begin
            n_cmp++;
            if (lowcnt != DEPTH) begin
                n_bad++;
                $display("FAIL ready_low_cycles: got %0d required %0d", lowcnt, DEPTH);
            end
            idle_inputs();
            cycle("init_last", model_exp());
            check("ready_rises", DW'(ready), DW'(1));
            model_run = 1'b1;
        end
    endtask

    task automatic zero_sweep(input string nm);
        idle_inputs();
        ra[0] = AW'(DEPTH - 1); ra[1] = '0; ra[2] = AW'(5); ra[3] = AW'(7);
        cycle(nm, quad_t'(0));
        for (int i = 0; i < 40; i++) begin
            rand_inputs(1'b0);
            cycle(nm, model_exp());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_run = 1'b0;
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Power-up: full clear, then everything reads zero.
        do_reset(1'b1);
        zero_sweep("post_init_zero");

        // Directed vectors; expectation is the read issued in that row.
        vt[0]  = mk(1, 5, 32'hA5, 0, 0, 0,        5, 5, 5, 5,
                    BYP ? 32'hA5 : 0, BYP ? 32'hA5 : 0, BYP ? 32'hA5 : 0, BYP ? 32'hA5 : 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0,             5, 5, 5, 5, 32'hA5, 32'hA5, 32'hA5, 32'hA5);
        vt[2]  = mk(1, 7, 32'h11, 0, 0, 0,        5, 0, 7, 1, 32'hA5, 0, BYP ? 32'h11 : 0, 0);
        vt[3]  = mk(0, 0, 0, 1, 7, 32'h22,        7, 7, 7, 7,
                    BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11,
                    BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11);
        vt[4]  = mk(0, 0, 0, 0, 0, 0,             7, 7, 7, 7, 32'h22, 32'h22, 32'h22, 32'h22);
        vt[5]  = mk(1, 9, 32'h33, 1, 9, 32'h44,   9, 9, 9, 9,
                    BYP ? 32'h33 : 0, BYP ? 32'h33 : 0, BYP ? 32'h33 : 0, BYP ? 32'h33 : 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 0,             9, 9, 9, 9, 32'h33, 32'h33, 32'h33, 32'h33);
        vt[7]  = mk(1, 3, 32'h01, 1, 10, 32'hBEEF, 3, 10, 9, 7,
                    BYP ? 32'h01 : 0, BYP ? 32'hBEEF : 0, 32'h33, 32'h22);
        vt[8]  = mk(1, 3, 32'h02, 0, 0, 0,        3, 10, 3, 5,
                    BYP ? 32'h02 : 32'h01, 32'hBEEF, BYP ? 32'h02 : 32'h01, 32'hA5);
        vt[9]  = mk(0, 0, 0, 0, 0, 0,             3, 3, 3, 3, 32'h02, 32'h02, 32'h02, 32'h02);
        vt[10] = mk(1, 0, 32'h12345678, 1, DEPTH - 1, 32'hFFFFFFFF, DEPTH - 1, 0, 5, 9,
                    BYP ? 32'hFFFFFFFF : 0, BYP ? 32'h12345678 : 0, 32'hA5, 32'h33);
        vt[11] = mk(0, 0, 0, 0, 0, 0,             DEPTH - 1, 0, DEPTH - 1, 0,
                    32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h12345678);
        vt[12] = mk(0, 0, 0, 1, 5, 32'h55,        5, 5, 7, 9,
                    BYP ? 32'h55 : 32'hA5, BYP ? 32'h55 : 32'hA5, 32'h22, 32'h33);
        vt[13] = mk(1, 5, 32'h66, 1, 6, 32'h77,   5, 6, 5, 6,
                    BYP ? 32'h66 : 32'h55, BYP ? 32'h77 : 0, BYP ? 32'h66 : 32'h55, BYP ? 32'h77 : 0);
        vt[14] = mk(0, 0, 0, 0, 0, 0,             5, 6, 3, 7, 32'h66, 32'h77, 32'h02, 32'h22);

        for (int i = 0; i < 15; i++) begin
            en_w1 = vt[i].e1; w1_addr = vt[i].a1; w1_din = vt[i].v1;
            en_w2 = vt[i].e2; w2_addr = vt[i].a2; w2_din = vt[i].v2;
            for (int r = 0; r < 4; r++) ra[r] = vt[i].rd[r];
            cycle($sformatf("vec%0d", i), vt[i].exp);
        end

        // Random traffic against the reference array.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(1'b1);
            cycle("random", model_exp());
        end

        // Mid-run reset, then a reset during INIT, then a full clear.
        do_reset(1'b0);
        do_reset(1'b1);
        zero_sweep("post_rerun_zero");

        for (int i = 0; i < 500; i++) begin
            rand_inputs(1'b1);
            cycle("random_after_reset", model_exp());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
